// File: rtl/display_scanout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : display_scanout
// Function : Raster timing generator that reads one complete buffered frame
//            in raster order and hands the buffer back via Buf1Empty.
//            Optional idle colour bars: define SCANOUT_COLORBAR_EN.
// Revision : 1.0
// ============================================================================
module display_scanout #(
  parameter int H_ACTIVE = 100,
  parameter int V_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 8,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Buffer1Full,
  input  logic [7:0]  R1,
  input  logic [7:0]  G1,
  input  logic [7:0]  B1,
  output logic        RE1,
  output logic [19:0] Addr1,
  output logic        Buf1Empty,
  output logic [7:0]  R_out,
  output logic [7:0]  G_out,
  output logic [7:0]  B_out,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [19:0]   ADDR_LAST = 20'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            full_prev_q;
  logic            re1_q, re1_d;
  logic [19:0]     addr_q, addr_d;
  logic            frame_done_q, frame_done_d;
  logic            de1_q, hs1_q, vs1_q, scan1_q;
  logic            de_q, hs_q, vs_q;
  logic [23:0]     pix_q, pix_d;
  logic [23:0]     idle_rgb;
  logic            frame_wrap, full_rise, last_read;
  logic            act_now, act_next, hs_now, vs_now;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  assign frame_wrap = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign full_rise  = Buffer1Full && !full_prev_q;
  assign last_read  = re1_q && (addr_q == ADDR_LAST);
  assign act_now    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign act_next   = (h_cnt_d < H_ACT_C) && (v_cnt_d < V_ACT_C);
  assign hs_now     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_now     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

  // READY arms on the last clock of a frame so SCAN owns the whole next frame.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_EMPTY: if (full_rise)  state_d = S_READY;
      S_READY: if (frame_wrap) state_d = S_SCAN;
      S_SCAN: begin
        if (last_read) begin
          state_d      = S_EMPTY;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    re1_d = (state_d == S_SCAN) && act_next;
    if (frame_wrap)  addr_d = '0;
    else if (re1_q)  addr_d = addr_q + 20'd1;
    else             addr_d = addr_q;
  end

`ifdef SCANOUT_COLORBAR_EN
  localparam int            BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [HW-1:0] BAR_W_C = HW'(BAR_W);
  logic [HW-1:0] bar_num;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb_d, bar_rgb_q;

  // Bar order maps to RGB as R=~idx[1], G=~idx[2], B=~idx[0].
  always_comb begin
    bar_num   = h_cnt_q / BAR_W_C;
    bar_idx   = (bar_num > HW'(7)) ? 3'd7 : bar_num[2:0];
    bar_rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bar_rgb_q <= '0;
    else        bar_rgb_q <= bar_rgb_d;
  end

  assign idle_rgb = bar_rgb_q;
`else
  assign idle_rgb = '0;
`endif

  always_comb begin
    pix_d = '0;
    if (de1_q) pix_d = scan1_q ? {R1, G1, B1} : idle_rgb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_EMPTY;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      full_prev_q  <= 1'b1;  // a level already high at release is not an edge
      re1_q        <= 1'b0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      de1_q        <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      scan1_q      <= 1'b0;
      de_q         <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      full_prev_q  <= Buffer1Full;
      re1_q        <= re1_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      de1_q        <= act_now;
      hs1_q        <= hs_now;
      vs1_q        <= vs_now;
      scan1_q      <= re1_q;
      de_q         <= de1_q;
      hs_q         <= hs1_q;
      vs_q         <= vs1_q;
      pix_q        <= pix_d;
    end
  end

  assign RE1                   = re1_q;
  assign Addr1                 = addr_q;
  assign Buf1Empty             = (state_q == S_EMPTY);
  assign frame_done            = frame_done_q;
  assign {R_out, G_out, B_out} = pix_q;
  assign de                    = de_q;
  assign hsync                 = hs_q;
  assign vsync                 = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scanout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_display_scanout
// Function : Scoreboard bench for display_scanout (honours SCANOUT_COLORBAR_EN).
// Revision : 1.0
// ============================================================================
module tb_display_scanout;

  localparam int HT = 120;
  localparam int VT = 108;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        Buffer1Full;
  logic [7:0]  R1 = 8'h0;
  logic [7:0]  G1 = 8'h0;
  logic [7:0]  B1 = 8'h0;
  logic        RE1;
  logic [19:0] Addr1;
  logic        Buf1Empty;
  logic [7:0]  R_out, G_out, B_out;
  logic        de, hsync, vsync, frame_done;

  display_scanout dut (
    .clk(clk), .reset(reset), .Buffer1Full(Buffer1Full),
    .R1(R1), .G1(G1), .B1(B1),
    .RE1(RE1), .Addr1(Addr1), .Buf1Empty(Buf1Empty),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .de(de), .hsync(hsync), .vsync(vsync), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Buffer returns its own address as pixel data, one cycle after RE1.
  always @(posedge clk) begin
    if (RE1) begin
      R1 <= Addr1[7:0];
      G1 <= Addr1[15:8];
      B1 <= {4'b0, Addr1[19:16]};
    end
  end

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int seg = 1;
  int t_full1, t_done, t_full2;
  int re1_f2 = 0, de_f2 = 0, de_l0 = 0;
  logic [23:0] exp_q[$];

`ifdef SCANOUT_COLORBAR_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s seg=%0d cyc=%0d: got %h expected %h", name, seg, cyc, act, exp);
    end
  endtask

  function automatic bit px_active(input int c);
    return ((c % HT) < 100) && (((c / HT) % VT) < 100);
  endfunction

  function automatic bit is_scan(input int c);
    return (seg == 1) && ((c / FR == 2) || (c / FR == 4));
  endfunction

  function automatic logic [23:0] exp_rgb(input int c);
    int h, v, idx;
    logic [19:0] a;
    h = c % HT;
    v = (c / HT) % VT;
    if (is_scan(c)) begin
      a = 20'(v * 100 + h);
      return {a[7:0], a[15:8], 4'b0, a[19:16]};
    end
`ifdef SCANOUT_COLORBAR_EN
    idx = h / 12;
    if (idx > 7) idx = 7;
    return bars[idx];
`else
    idx = 0;
    return 24'h000000;
`endif
  endfunction

  // Expected pixel of the current raster position.
  always @(negedge clk) begin
    if (reset && px_active(cyc)) exp_q.push_back(exp_rgb(cyc));
  end

  int          mq, mh, mv;
  logic        e_de, e_hs, e_vs, e_re, e_empty;
  logic [23:0] e_px;

  always @(negedge clk) begin
    if (reset) begin
      if (cyc < 2) begin
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        mq = cyc - 2;
        mh = mq % HT;
        mv = (mq / HT) % VT;
        e_de = (mh < 100) && (mv < 100);
        e_hs = !((mh >= 104) && (mh < 112));
        e_vs = !((mv >= 102) && (mv < 104));
      end
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      if (de) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pixel_underrun seg=%0d cyc=%0d: got de=1 expected no pixel", seg, cyc);
        end else begin
          e_px = exp_q.pop_front();
          chk("pixel", 32'({R_out, G_out, B_out}), 32'(e_px));
        end
      end else begin
        chk("blank_rgb", 32'({R_out, G_out, B_out}), 32'h0);
      end
      e_re = is_scan(cyc) && px_active(cyc);
      chk("re1", 32'(RE1), 32'(e_re));
      if (e_re) chk("addr1", 32'(Addr1), 32'(((cyc / HT) % VT) * 100 + (cyc % HT)));
      e_empty = !(((cyc > t_full1) && (cyc <= t_done)) || (cyc > t_full2));
      chk("buf1empty", 32'(Buf1Empty), 32'(e_empty));
      chk("frame_done", 32'(frame_done), 32'(cyc == t_done + 1));
      if (seg == 1 && RE1 && (cyc / FR == 2)) re1_f2++;
      if (seg == 1 && de && cyc >= 2 && ((cyc - 2) / FR == 2)) begin
        de_f2++;
        if (((cyc - 2) % FR) < HT) de_l0++;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_re1"}, 32'(RE1), 32'h0);
    chk({tag, "_addr1"}, 32'(Addr1), 32'h0);
    chk({tag, "_buf1empty"}, 32'(Buf1Empty), 32'h1);
    chk({tag, "_rgb"}, 32'({R_out, G_out, B_out}), 32'h0);
    chk({tag, "_de"}, 32'(de), 32'h0);
    chk({tag, "_hsync"}, 32'(hsync), 32'h1);
    chk({tag, "_vsync"}, 32'(vsync), 32'h1);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc != target) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout seg=%0d cyc=%0d: got no finish expected finish", seg, cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    Buffer1Full = 1'b0;
    t_full1     = 12960 + 5000;
    t_done      = 2 * FR + 99 * HT + 99;
    t_full2     = 3 * FR + 5000;
    repeat (3) @(negedge clk);
    chk_reset_vals("init");
    @(posedge clk);
    #1 reset = 1'b1;

    // Frame 1: full edge mid-frame -> frame 2 is scanned.
    wait_cyc(t_full1);
    Buffer1Full = 1'b1;
    // Edge inside the SCAN frame must be ignored.
    wait_cyc(2 * FR + 10 * HT);
    Buffer1Full = 1'b0;
    wait_cyc(2 * FR + 20 * HT);
    Buffer1Full = 1'b1;
    // Frame 3: fresh edge -> frame 4 is scanned, then aborted at pixel 5000.
    wait_cyc(3 * FR + 100);
    Buffer1Full = 1'b0;
    wait_cyc(t_full2);
    Buffer1Full = 1'b1;
    wait_cyc(4 * FR + 50 * HT);
    #2 reset = 1'b0;
    #1 chk_reset_vals("abort");

    exp_q.delete();
    seg     = 2;
    t_full1 = 32'h3FFF_FFFF;
    t_done  = 32'h3FFF_FFFF;
    t_full2 = 32'h3FFF_FFFF;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    // Buffer1Full held high across release: no scan may start.
    wait_cyc(FR + 300);

    chk("re1_count_f2", 32'(re1_f2), 32'd10000);
    chk("de_count_f2", 32'(de_f2), 32'd10000);
    chk("de_line0_f2", 32'(de_l0), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scanout.md
# display_scanout

Downstream consumer of the single-frame pixel buffer. It generates display raster timing and reads the buffer in raster order once per frame whenever a complete frame is available. It drives the pixel stream with hsync/vsync/de and hands the buffer back to the writer, via `Buf1Empty`, after the last pixel has been read.

## Interface
Parameters:
- `H_ACTIVE`, 100, active pixels per line
- `V_ACTIVE`, 100, active lines per frame
- `H_FP` / `H_SYNC` / `H_BP`, 4 / 8 / 8, horizontal porch and sync widths in clocks
- `V_FP` / `V_SYNC` / `V_BP`, 2 / 2 / 4, vertical porch and sync widths in lines
- Derived: `H_TOTAL` = 120, `V_TOTAL` = 108, frame length = 12960 clocks

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `Buffer1Full` in 1: buffer-full level from the buffer
- `R1`, `G1`, `B1` in 8 each: buffer read data, valid 1 cycle after `RE1`
- `RE1` out 1: buffer read enable
- `Addr1` out 20: buffer read address
- `Buf1Empty` out 1: buffer granted to writer
- `R_out`, `G_out`, `B_out` out 8 each: display pixel
- `de` out 1: data enable
- `hsync`, `vsync` out 1 each: active-low sync pulses
- `frame_done` out 1: one-cycle pulse when a buffered frame finishes reading

## Operation
- Free-running counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1) start at 0 after reset.
  - `v_cnt` increments when `h_cnt` wraps.
  - Both wrap to 0 together at the frame end.
- Pixel is active when `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- `hsync` is low for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- `vsync` is low for `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- The address is an incrementing counter, with no multiplier:
  - Reset to 0 at the frame start.
  - Increments on each active pixel of a SCAN frame, 0..H_ACTIVE*V_ACTIVE-1 (0..9999).
- FSM states:
  - **EMPTY** (`Buf1Empty`=1): waits for a rising edge of `Buffer1Full`, registered previous value low and current value high. On that edge → READY. A level that is high without an edge (e.g. high out of reset) does not trigger.
  - **READY** (`Buf1Empty`=0): waits for `h_cnt`=0 and `v_cnt`=0 → SCAN. A full edge that arrives mid-frame waits for the next frame start; a partial frame is never shown.
  - **SCAN** (`Buf1Empty`=0): asserts `RE1` with `Addr1` on every active pixel. After issuing address H_ACTIVE*V_ACTIVE-1 → EMPTY and pulse `frame_done`.
- Edges of `Buffer1Full` in READY or SCAN are ignored.
- In frames that are not in SCAN, active pixels output black, or the test pattern (see Configuration). `RE1` stays 0.

## Timing
- Reset values: all outputs 0 except `hsync`=1, `vsync`=1, `Buf1Empty`=1. The FSM resets to EMPTY and all counters to 0.
- Reset is asynchronous. Asserting it mid-SCAN aborts the frame immediately, and the FSM returns to EMPTY.
- Pipeline for pixel p, with `RE1`/`Addr1` driven (registered) in cycle c:
  - `R1`/`G1`/`B1` are valid in cycle c+1.
  - `R_out`/`G_out`/`B_out`, `de`, `hsync`, `vsync` for p are registered and valid in cycle c+2.
  - All display outputs stay mutually aligned, so sync and de are delayed to match the data.
- `Buf1Empty` rises in the cycle after `RE1` is driven for address 9999. `frame_done` pulses in that same cycle.
- EMPTY→READY: `Buf1Empty` falls one cycle after the cycle in which the `Buffer1Full` rising edge is sampled.
- When `de`=0, `R_out`/`G_out`/`B_out` are 0.

## Configuration
- `SCANOUT_COLORBAR_EN` defined:
  - Active pixels of non-SCAN frames show 8 vertical bars, each H_ACTIVE/8 pixels wide. The last bar absorbs the remainder.
  - Bar colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- `SCANOUT_COLORBAR_EN` undefined:
  - Non-SCAN active pixels are 000000.
  - No bar logic is present.

## Test plan
- Reset with `reset`=0, then release, with `Buffer1Full`=0:
  - `Buf1Empty`=1, `RE1`=0, `hsync`/`vsync`=1, `de`=0.
  - First `hsync` low at `h_cnt`=104 (output 2 cycles later), 8 clocks wide.
  - `vsync` low for 2 lines starting at line 102.
- Take `Buffer1Full` 0→1 mid-frame; buffer model returns data = address:
  - `Buf1Empty` falls next cycle.
  - `RE1` first asserts at the next frame start with `Addr1`=0.
  - `R_out`=0x00 two cycles later with `de`=1.
  - The last read is `Addr1`=9999 (0x270F, R=0x0F, G=0x27).
  - `Buf1Empty`=1 and `frame_done` pulse follow in the next cycle.
- Hold `Buffer1Full`=1 from before reset release → no SCAN ever; `Buf1Empty` stays 1.
- Assert `reset` at pixel 5000 of a SCAN frame:
  - All outputs return to their reset values immediately.
  - After release, a new full edge is required before the next scan.
- With `SCANOUT_COLORBAR_EN`, in an idle frame:
  - Pixel `h_cnt`=0 → FFFFFF.
  - `h_cnt`=12 → FFFF00.
  - `h_cnt`=99 → 000000.
- Without the macro, the same pixels are all 000000.
- Check `de` alignment in a SCAN frame: exactly 100 `de`-high cycles per active line and 10000 per frame; count of `RE1`-high cycles = 10000.
